// File: rtl/cpu_pkg.sv
// Shared CPU definitions: condition-code encodings, flag bit positions and
// flag-write-enable encodings used by the decoder/condition logic.
package cpu_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [1:0] FW_NONE = 2'b00;
  localparam logic [1:0] FW_CV   = 2'b01;
  localparam logic [1:0] FW_NZ   = 2'b10;
  localparam logic [1:0] FW_ALL  = 2'b11;

endpackage

// File: rtl/cond_check.sv
// Combinational ARM-style condition evaluator: (cond, flags) -> cond_ex.
// Kept stand-alone so other pipeline stages can reuse it.
module cond_check
  import cpu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    cond_ex = 1'b1;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = !z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = !c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = !n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = !v;
      COND_HI: cond_ex = c & !z;
      COND_LS: cond_ex = !c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = !z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      default: cond_ex = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Conditional-execution unit: holds the architectural NZCV flags, evaluates the
// instruction condition against them and gates the decoder's write controls.
module cond_unit
  import cpu_pkg::*;
#(
  parameter bit         OUT_REG   = 1'b1,
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid_in,
  input  logic       stall,
  input  logic       flush,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic [1:0] flag_w,
  input  logic       pcs,
  input  logic       reg_w,
  input  logic       mem_w,
  input  logic       no_write,
  output logic       cond_ex,
  output logic [3:0] flags,
  output logic       pc_src,
  output logic       reg_write,
  output logic       mem_write,
  output logic       valid_out
);

  logic [3:0] flags_reg;
  logic       live;
  logic       pc_src_next;
  logic       reg_write_next;
  logic       mem_write_next;

  cond_check u_cond_check (
    .cond    (cond),
    .flags   (flags_reg),
    .cond_ex (cond_ex)
  );

  // valid_in is ANDed first so X on cond while idle cannot reach the flags
  assign live           = valid_in & cond_ex & !flush;
  assign pc_src_next    = pcs & live;
  assign reg_write_next = reg_w & !no_write & live;
  assign mem_write_next = mem_w & live;
  assign flags          = flags_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_reg <= FLAGS_RST;
    end else if (live && !stall) begin
      if (flag_w[1]) flags_reg[FLAG_N:FLAG_Z] <= alu_flags[FLAG_N:FLAG_Z];
      if (flag_w[0]) flags_reg[FLAG_C:FLAG_V] <= alu_flags[FLAG_C:FLAG_V];
    end
  end

  generate
    if (OUT_REG) begin : g_out_reg
      logic pc_src_reg, reg_write_reg, mem_write_reg, valid_out_reg;

      // Flush wins over stall so a squashed instruction never lingers in the stage
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pc_src_reg    <= 1'b0;
          reg_write_reg <= 1'b0;
          mem_write_reg <= 1'b0;
          valid_out_reg <= 1'b0;
        end else if (flush) begin
          pc_src_reg    <= 1'b0;
          reg_write_reg <= 1'b0;
          mem_write_reg <= 1'b0;
          valid_out_reg <= 1'b0;
        end else if (!stall) begin
          pc_src_reg    <= pc_src_next;
          reg_write_reg <= reg_write_next;
          mem_write_reg <= mem_write_next;
          valid_out_reg <= live;
        end
      end

      assign pc_src    = pc_src_reg;
      assign reg_write = reg_write_reg;
      assign mem_write = mem_write_reg;
      assign valid_out = valid_out_reg;
    end else begin : g_out_comb
      assign pc_src    = pc_src_next;
      assign reg_write = reg_write_next;
      assign mem_write = mem_write_next;
      assign valid_out = live & !stall;
    end
  endgenerate

endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit (OUT_REG=1): directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a flag model.
module tb_cond_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       valid_in = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [3:0] cond = 4'h0, alu_flags = 4'h0;
  logic [1:0] flag_w = 2'b00;
  logic       pcs = 1'b0, reg_w = 1'b0, mem_w = 1'b0, no_write = 1'b0;
  logic       cond_ex, pc_src, reg_write, mem_write, valid_out;
  logic [3:0] flags;

  int passed = 0;
  int total  = 0;
  bit chk_en = 1'b0;

  // model state
  logic [3:0] m_flags;
  logic       m_pc, m_rw, m_mw, m_vo;

  cond_unit #(.OUT_REG(1'b1), .FLAGS_RST(4'b0000)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .stall(stall), .flush(flush),
    .cond(cond), .alu_flags(alu_flags), .flag_w(flag_w), .pcs(pcs), .reg_w(reg_w),
    .mem_w(mem_w), .no_write(no_write), .cond_ex(cond_ex), .flags(flags),
    .pc_src(pc_src), .reg_write(reg_write), .mem_write(mem_write), .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  // ARM conditions come in complementary pairs: cond[3:1] picks the test, cond[0] inverts
  function automatic logic passes(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return (c[3:1] == 3'd7) ? 1'b1 : (base ^ c[0]);
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_flags = 4'b0000;
      {m_pc, m_rw, m_mw, m_vo} = 4'b0000;
    end else begin
      logic lv;
      lv = valid_in && passes(cond, m_flags) && !flush;
      if (flush) begin
        {m_pc, m_rw, m_mw, m_vo} = 4'b0000;
      end else if (!stall) begin
        m_pc = pcs && lv;
        m_rw = reg_w && !no_write && lv;
        m_mw = mem_w && lv;
        m_vo = lv;
      end
      if (lv && !stall) begin
        if (flag_w[1]) m_flags[3:2] = alu_flags[3:2];
        if (flag_w[0]) m_flags[1:0] = alu_flags[1:0];
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_flags", flags, m_flags);
      check("cyc_cond_ex", {3'b0, cond_ex}, {3'b0, passes(cond, m_flags)});
      check("cyc_outs", {pc_src, reg_write, mem_write, valid_out}, {m_pc, m_rw, m_mw, m_vo});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [3:0] c, input logic [1:0] fw,
                        input logic [3:0] alu, input logic p, input logic rw,
                        input logic mw, input logic nw);
    valid_in = v; cond = c; flag_w = fw; alu_flags = alu;
    pcs = p; reg_w = rw; mem_w = mw; no_write = nw;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    tick(); tick();
    chk_en = 1'b1;
    check("rst_flags", flags, 4'b0000);
    check("rst_outs", {pc_src, reg_write, mem_write, valid_out}, 4'b0000);
    rst_n = 1'b1;

    // AL with reg_w -> reg_write one cycle later
    set_in(1, 4'b1110, 2'b00, 4'h0, 0, 1, 0, 0);
    tick();
    check("al_reg_write", {3'b0, reg_write}, 4'd1);
    check("al_valid_out", {3'b0, valid_out}, 4'd1);

    // CMP sets Z, no register write
    set_in(1, 4'b1110, 2'b11, 4'b0100, 0, 1, 0, 1);
    tick();
    check("cmp_reg_write", {3'b0, reg_write}, 4'd0);
    check("cmp_flags", flags, 4'b0100);

    set_in(1, 4'b0000, 2'b00, 4'h0, 0, 1, 0, 0);
    #1 check("eq_cond_ex", {3'b0, cond_ex}, 4'd1);
    tick();
    check("eq_reg_write", {3'b0, reg_write}, 4'd1);

    set_in(1, 4'b0001, 2'b00, 4'h0, 1, 1, 1, 0);
    #1 check("ne_cond_ex", {3'b0, cond_ex}, 4'd0);
    tick();
    check("ne_outs", {pc_src, reg_write, mem_write, valid_out}, 4'b0000);

    // partial write: 1010 + CV<-11 -> 1011
    set_in(1, 4'b1110, 2'b11, 4'b1010, 0, 0, 0, 0);
    tick();
    check("set_1010", flags, 4'b1010);
    set_in(1, 4'b1110, 2'b01, 4'b0111, 0, 0, 0, 0);
    tick();
    check("partial_flags", flags, 4'b1011);
    set_in(1, 4'b1010, 2'b00, 4'h0, 0, 0, 0, 0);
    #1 check("ge_cond_ex", {3'b0, cond_ex}, 4'd1);
    set_in(1, 4'b1011, 2'b00, 4'h0, 0, 0, 0, 0);
    #1 check("lt_cond_ex", {3'b0, cond_ex}, 4'd0);
    tick();

    // failed condition must not write flags
    set_in(1, 4'b1110, 2'b11, 4'b0000, 0, 0, 0, 0);
    tick();
    set_in(1, 4'b0000, 2'b11, 4'b1111, 1, 0, 1, 0);
    tick();
    check("fail_flags", flags, 4'b0000);
    check("fail_outs", {pc_src, mem_write, valid_out}, 3'b000);

    // stall freezes flags and outputs; stall+flush clears outputs only
    set_in(1, 4'b1110, 2'b00, 4'h0, 0, 1, 0, 0);
    tick();
    stall = 1'b1;
    set_in(1, 4'b1110, 2'b11, 4'b1111, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_flags", flags, 4'b0000);
      check("stall_reg_write", {3'b0, reg_write}, 4'd1);
    end
    flush = 1'b1;
    tick();
    check("sf_outs", {pc_src, reg_write, mem_write, valid_out}, 4'b0000);
    check("sf_flags", flags, 4'b0000);
    stall = 1'b0; flush = 1'b0;

    // async reset between edges
    set_in(1, 4'b1110, 2'b11, 4'b1111, 0, 1, 0, 0);
    tick();
    check("pre_rst_flags", flags, 4'b1111);
    check("pre_rst_reg_write", {3'b0, reg_write}, 4'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_flags", flags, 4'b0000);
    check("async_reg_write", {3'b0, reg_write}, 4'd0);
    set_in(0, 4'h0, 2'b00, 4'h0, 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;

    // randomized traffic, checked by the per-cycle compare process
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 3) != 0, 4'($urandom), 2'($urandom), 4'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0);
      stall = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 7) == 0);
      tick();
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cond_unit.md
Name: cond_unit

Overview:
- Consumer side of the ALU flag interface: latches the 4-bit alu_flags bus {N,Z,C,V} into an architectural flags register.
- Evaluates each instruction's 4-bit ARM-style condition field against the stored flags.
- Gates the control writes (PC source, register write, memory write) with the condition result.
- Sits between the main decoder and the datapath, with a registered output stage and stall/flush control.

Parameters:
- OUT_REG, 1: 1 = gated control outputs are registered (latency 1); 0 = outputs are combinational (latency 0); flags register is always sequential.
- FLAGS_RST, 4'b0000: reset value of the flags register, bit order {N,Z,C,V}.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- valid_in  input  1  decoded instruction present this cycle.
- stall  input  1  hold all state; no flag or output update.
- flush  input  1  squash the current instruction.
- cond  input  4  condition field, instr[31:28].
- alu_flags  input  4  {neg,zero,carry,overflow} from the ALU for the current instruction.
- flag_w  input  2  flag write enables: [1] updates N,Z; [0] updates C,V.
- pcs  input  1  decoder PC-source request.
- reg_w  input  1  decoder register-write request.
- mem_w  input  1  decoder memory-write request.
- no_write  input  1  suppress register write (compare-class ops).
- cond_ex  output  1  condition passed (combinational, against stored flags).
- flags  output  4  current flags register contents {N,Z,C,V}.
- pc_src  output  1  gated pcs.
- reg_write  output  1  gated reg_w.
- mem_write  output  1  gated mem_w.
- valid_out  output  1  gated outputs carry a live instruction.

Behaviour:
- Reset (rst_n low, asynchronous): flags = FLAGS_RST; pc_src, reg_write, mem_write, valid_out = 0. Applies immediately, including mid-stall or mid-flush. Release is synchronous to the next clk edge.
- Condition evaluation is pure combinational on (cond, flags register), never on alu_flags:
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 0010 CS: C
  - 0011 CC: !C
  - 0100 MI: N
  - 0101 PL: !N
  - 0110 VS: V
  - 0111 VC: !V
  - 1000 HI: C & !Z
  - 1001 LS: !C | Z
  - 1010 GE: N == V
  - 1011 LT: N != V
  - 1100 GT: !Z & (N == V)
  - 1101 LE: Z | (N != V)
  - 1110 AL: 1
  - 1111: 1
- Gating: live = valid_in & cond_ex & !flush.
  - pc_src_n = pcs & live
  - reg_write_n = reg_w & !no_write & live
  - mem_write_n = mem_w & live
- Flag write at rising edge when live & !stall:
  - flag_w[1] = 1 → N,Z take alu_flags[3:2].
  - flag_w[0] = 1 → C,V take alu_flags[1:0].
  - Unselected bits are held.
  - A failed condition never writes flags.
- Flag visibility: a write is visible to the next instruction's cond_ex, one cycle later. There is no same-cycle bypass.
- OUT_REG=1:
  - On a rising edge with !stall, output registers load the *_n values and valid_out loads live.
  - stall = 1: all registers hold.
  - flush = 1 (with or without stall): output registers clear to 0 on the next edge and no flag write occurs. Flush has priority over stall.
- OUT_REG=0: outputs equal the *_n values; valid_out = live & !stall.
- Signal purity: X on cond or alu_flags while valid_in = 0 must not propagate into flags.

Decomposition:
- Shared package cpu_pkg:
  - condition-code localparams COND_EQ … COND_AL, COND_NV
  - flag bit indices FLAG_N = 3, FLAG_Z = 2, FLAG_C = 1, FLAG_V = 0
  - flag_w encodings FW_NONE, FW_CV, FW_NZ, FW_ALL
- One sub-module, cond_check: purely combinational (cond, flags) → cond_ex, reusable by a future branch predictor.

Test Plan:
- Reset then release: flags = 0000 and all outputs 0. Then cond = 1110, valid_in = 1, reg_w = 1 → reg_write = 1 one cycle later (OUT_REG=1).
- CMP sets Z: valid_in = 1, cond = AL, flag_w = 11, alu_flags = 0100, no_write = 1 → reg_write = 0 and flags = 0100 after the edge. Next instruction with cond = EQ and reg_w = 1 → cond_ex = 1 and reg_write = 1; cond = NE → cond_ex = 0 and all gated outputs 0.
- Partial write: flags = 1010, flag_w = 01, alu_flags = 0111 → flags = 1011. GE then evaluates 1 (N = V = 1); LT evaluates 0.
- Failed condition: flags = 0000, cond = EQ, flag_w = 11, alu_flags = 1111 → flags remain 0000; pc_src, mem_write, valid_out = 0.
- Stall/flush: stall = 1 for 3 cycles with flag_w = 11 → flags and outputs frozen. stall = 1 and flush = 1 together → outputs cleared next edge, flags unchanged.
- Async reset mid-operation: assert rst_n = 0 between clock edges while reg_write = 1 and flags = 1111 → both clear before the next edge.
